// File: rtl/cache_pkg.sv
// Shared constants, types and address helpers for the direct-mapped 4-word-line cache.
// Address layout: tag = [14:12], index = [11:2], offset = [1:0].
package cache_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int LINES  = 1024;
   localparam int WORDS  = 4;

   localparam int IDX_W  = $clog2(LINES);
   localparam int OFF_W  = $clog2(WORDS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [OFF_W-1:0]  off_t;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      REFILL,
      RESP
   } ctrl_state_t;

   function automatic tag_t addr_tag(input addr_t a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic idx_t addr_idx(input addr_t a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic off_t addr_off(input addr_t a);
      return a[OFF_W-1:0];
   endfunction

   function automatic addr_t make_addr(input tag_t t, input idx_t i, input off_t o);
      return {t, i, o};
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU load port and main-memory read port of the cache controller.
// The controller uses the slave modport; the CPU/memory side uses master.
interface cache_controller_if;
   import cache_pkg::*;

   logic  cpu_req_valid;
   logic  cpu_req_ready;
   addr_t cpu_addr;
   logic  cpu_rsp_valid;
   word_t cpu_rsp_data;
   logic  cpu_rsp_hit;
   logic  mem_req;
   addr_t mem_addr;
   logic  mem_ack;
   word_t mem_data;

   modport slave (
      input  cpu_req_valid,
      input  cpu_addr,
      input  mem_ack,
      input  mem_data,
      output cpu_req_ready,
      output cpu_rsp_valid,
      output cpu_rsp_data,
      output cpu_rsp_hit,
      output mem_req,
      output mem_addr
   );

   modport master (
      output cpu_req_valid,
      output cpu_addr,
      output mem_ack,
      output mem_data,
      input  cpu_req_ready,
      input  cpu_rsp_valid,
      input  cpu_rsp_data,
      input  cpu_rsp_hit,
      input  mem_req,
      input  mem_addr
   );

endinterface

// File: rtl/cache_line_store.sv
// Data, tag and valid storage for the cache: one write port, combinational read.
// Valid bits clear asynchronously; data and tag contents are left unreset.
module cache_line_store
   import cache_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  wr_en,
   input  idx_t  wr_idx,
   input  off_t  wr_off,
   input  word_t wr_data,
   input  tag_t  wr_tag,
   input  idx_t  rd_idx,
   input  off_t  rd_off,
   output word_t rd_word,
   output tag_t  rd_tag,
   output logic  rd_valid
);

   word_t             data_mem [LINES*WORDS];
   tag_t              tag_mem  [LINES];
   logic [LINES-1:0]  valid_q;
   logic              wr_last;

   // Tag and valid are committed only with the final word, so a partial line never looks valid.
   assign wr_last = wr_en && (wr_off == off_t'(WORDS - 1));

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[{wr_idx, wr_off}] <= wr_data;
      end
      if (wr_last) begin
         tag_mem[wr_idx] <= wr_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_last) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   assign rd_word  = data_mem[{rd_idx, rd_off}];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Read-only direct-mapped cache sequencer: lookup, word-by-word refill, one-cycle response.
// Define CACHE_CTRL_STATS_EN to add saturating hit/miss counters as extra outputs.
module cache_controller
   import cache_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   cache_controller_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_misses
`endif
);

   ctrl_state_t state_q, state_d;
   addr_t       addr_q, addr_d;
   off_t        cnt_q, cnt_d;
   word_t       rsp_data_q, rsp_data_d;
   logic        rsp_hit_q, rsp_hit_d;

   logic  wr_en;
   word_t rd_word;
   tag_t  rd_tag;
   logic  rd_valid;
   logic  lookup_hit;
   logic  last_word;

   cache_line_store u_store (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_idx   (addr_idx(addr_q)),
      .wr_off   (cnt_q),
      .wr_data  (bus.mem_data),
      .wr_tag   (addr_tag(addr_q)),
      .rd_idx   (addr_idx(addr_q)),
      .rd_off   (addr_off(addr_q)),
      .rd_word  (rd_word),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid)
   );

   assign lookup_hit = rd_valid && (rd_tag == addr_tag(addr_q));
   assign last_word  = (cnt_q == off_t'(WORDS - 1));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_hit_d  = rsp_hit_q;
      wr_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req_valid) begin
               addr_d  = bus.cpu_addr;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (lookup_hit) begin
               rsp_data_d = rd_word;
               rsp_hit_d  = 1'b1;
               state_d    = RESP;
            end else begin
               cnt_d   = '0;
               state_d = REFILL;
            end
         end
         REFILL: begin
            if (bus.mem_ack) begin
               wr_en = 1'b1;
               if (last_word) begin
                  // Earlier words of this line are already in the array; the last one is still on the bus.
                  rsp_data_d = (addr_off(addr_q) == off_t'(WORDS - 1)) ? bus.mem_data : rd_word;
                  rsp_hit_d  = 1'b0;
                  state_d    = RESP;
               end else begin
                  cnt_d = cnt_q + off_t'(1);
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_hit_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_hit_q  <= rsp_hit_d;
      end
   end

   // Handshake outputs decode straight from state so a reset drops mem_req without waiting for a clock.
   assign bus.cpu_req_ready = (state_q == IDLE);
   assign bus.cpu_rsp_valid = (state_q == RESP);
   assign bus.cpu_rsp_data  = rsp_data_q;
   assign bus.cpu_rsp_hit   = rsp_hit_q;
   assign bus.mem_req       = (state_q == REFILL);
   assign bus.mem_addr      = (state_q == REFILL) ?
                              make_addr(addr_tag(addr_q), addr_idx(addr_q), cnt_q) : '0;

`ifdef CACHE_CTRL_STATS_EN
   logic [31:0] stat_hits_q, stat_hits_d;
   logic [31:0] stat_misses_q, stat_misses_d;

   always_comb begin
      stat_hits_d   = stat_hits_q;
      stat_misses_d = stat_misses_q;
      if (state_q == RESP) begin
         if (rsp_hit_q) begin
            if (stat_hits_q != 32'hFFFF_FFFF) stat_hits_d = stat_hits_q + 32'd1;
         end else begin
            if (stat_misses_q != 32'hFFFF_FFFF) stat_misses_d = stat_misses_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hits_q   <= '0;
         stat_misses_q <= '0;
      end else begin
         stat_hits_q   <= stat_hits_d;
         stat_misses_q <= stat_misses_d;
      end
   end

   assign stat_hits   = stat_hits_q;
   assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller: cold miss, hit, conflict eviction,
// wait-state refill, reset mid-refill and a sequential sweep.
module tb_cache_controller;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_controller_if bus ();

`ifdef CACHE_CTRL_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
`endif

   cache_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef CACHE_CTRL_STATS_EN
      ,
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory model: each word address returns a distinct pattern.
   function automatic word_t mem_word(input addr_t a);
      return {2'b10, a, a ^ 15'h2AAA};
   endfunction

   logic ack_slow = 1'b0;
   int   ack_div  = 0;
   always @(posedge clk) ack_div <= (ack_div == 2) ? 0 : ack_div + 1;
   assign bus.mem_ack  = ack_slow ? (ack_div == 2) : 1'b1;
   assign bus.mem_data = mem_word(bus.mem_addr);

   // Records each memory read that will complete on the next edge and checks mem_addr holds while stalled.
   addr_t rd_q[$];
   logic  prev_req = 1'b0;
   logic  prev_ack = 1'b0;
   addr_t prev_addr = '0;
   always @(negedge clk) begin
      if (bus.mem_req && bus.mem_ack) rd_q.push_back(bus.mem_addr);
      if (prev_req && !prev_ack && bus.mem_req) check("mem_addr_hold", bus.mem_addr, prev_addr);
      prev_req  <= bus.mem_req;
      prev_ack  <= bus.mem_ack;
      prev_addr <= bus.mem_addr;
   end

   task automatic do_req(input string name, input addr_t a, input logic exp_hit,
                         input int exp_lat, input int exp_reads, input bit verbose);
      int    k;
      bit    seen;
      addr_t base;
      k    = 0;
      seen = 0;
      base = a & ~addr_t'(WORDS - 1);
      @(negedge clk);
      rd_q.delete();
      check({name, "_ready"}, bus.cpu_req_ready, 1'b1);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr      = a;
      @(posedge clk);
      #1;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_addr      = 15'h5555;
      while (!seen && k < 200) begin
         @(negedge clk);
         k++;
         if (bus.cpu_rsp_valid) seen = 1;
      end
      check({name, "_timeout"}, seen, 1'b1);
      if (seen) begin
         if (exp_lat > 0) check({name, "_lat"}, k, exp_lat);
         check({name, "_data"}, bus.cpu_rsp_data, mem_word(a));
         check({name, "_hit"}, bus.cpu_rsp_hit, exp_hit);
         check({name, "_nreads"}, rd_q.size(), exp_reads);
         if (exp_reads == WORDS && rd_q.size() == WORDS) begin
            for (int i = 0; i < WORDS; i++) check({name, "_raddr"}, rd_q[i], base + addr_t'(i));
         end
         @(negedge clk);
         check({name, "_pulse"}, bus.cpu_rsp_valid, 1'b0);
      end
      if (verbose)
         $display("req %s addr=%04h data=%08h hit=%0d lat=%0d reads=%0d",
                  name, a, bus.cpu_rsp_data, bus.cpu_rsp_hit, k, rd_q.size());
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int    hits;
   int    misses;
   logic  exp_h;
   int    k;

   initial begin
      rst_n             = 1'b0;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_addr      = '0;
      #23;
      check("rst_ready", bus.cpu_req_ready, 1'b1);
      check("rst_rsp_valid", bus.cpu_rsp_valid, 1'b0);
      check("rst_rsp_data", bus.cpu_rsp_data, 32'h0);
      check("rst_rsp_hit", bus.cpu_rsp_hit, 1'b0);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 15'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold miss, hit, conflict eviction
      do_req("cold", 15'h0400, 1'b0, 6, 4, 1);
      do_req("hit", 15'h0402, 1'b1, 2, 0, 1);
      do_req("hit3", 15'h0403, 1'b1, 2, 0, 1);
      do_req("conf", 15'h1400, 1'b0, 6, 4, 1);
      do_req("conf_hit", 15'h1401, 1'b1, 2, 0, 1);
      do_req("evict", 15'h0400, 1'b0, 6, 4, 1);
      do_req("mid", 15'h0ABD, 1'b0, 6, 4, 1);

      // Wait-state memory at the top of the address space
      ack_slow = 1'b1;
      do_req("slow", 15'h7FFF, 1'b0, 0, 4, 1);
      do_req("slow_hit", 15'h7FFC, 1'b1, 2, 0, 1);
      ack_slow = 1'b0;

      // Reset in the middle of a refill after two acks
      @(negedge clk);
      rd_q.delete();
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr      = 15'h3123;
      @(posedge clk);
      #1;
      bus.cpu_req_valid = 1'b0;
      k = 0;
      while (rd_q.size() < 2 && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("abort_two_acks", rd_q.size(), 2);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_mem_req", bus.mem_req, 1'b0);
      check("abort_rsp_valid", bus.cpu_rsp_valid, 1'b0);
      check("abort_ready", bus.cpu_req_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_rsp", bus.cpu_rsp_valid, 1'b0);
      end
      $display("req abort addr=3123 reset after %0d acks", 2);
      do_req("rereq", 15'h3123, 1'b0, 6, 4, 1);
      do_req("pre_evict", 15'h0400, 1'b0, 6, 4, 1);

      // Sequential sweep from a clean reset
      do_reset();
      hits   = 0;
      misses = 0;
      for (int a = 16'h0400; a <= 16'h23FF; a++) begin
         exp_h = (a[1:0] != 2'b00);
         do_req("sweep", addr_t'(a), exp_h, exp_h ? 2 : 6, exp_h ? 0 : 4, 0);
         if (bus.cpu_rsp_hit) hits++;
         else misses++;
      end
      check("sweep_hits", hits, 6144);
      check("sweep_misses", misses, 2048);
      $display("sweep 0400..23FF hits=%0d misses=%0d", hits, misses);
`ifdef CACHE_CTRL_STATS_EN
      check("stat_hits", stat_hits, 32'd6144);
      check("stat_misses", stat_misses, 32'd2048);
      do_reset();
      check("stat_hits_rst", stat_hits, 32'd0);
      check("stat_misses_rst", stat_misses, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
